add_tree_seg: RTL
=================

Name: add_tree_seg

Overview:
- Parametrised, fully pipelined, segmented saturating adder tree; successor to the fixed 64-input tree.
- Reduces N_IN signed fixed-point words into one or more segment sums. Segment size is selected per transaction.
- All segment sums are emitted at one common latency, with valid, mode and side-band bypass aligned to them.
- Sits in the softmax datapath between exponent-approximation stage and normaliser (row-sum for 16/32/64-length rows).

Parameters:
- N_IN, 64, number of input words; power of two, 4..256.
- DW, 16, word width (signed two's complement fixed point).
- MIN_SEG_LOG2, 4, log2 of smallest supported segment; 1..log2(N_IN).
- BYP_W, 1024, width of side-band bypass bus.
- Derived, not overridable: LVL = log2(N_IN); NLANE = N_IN >> MIN_SEG_LOG2.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, synchronous active-low reset.
- i_en, in, 1, global pipeline enable; 0 freezes every register.
- i_valid, in, 1, input transaction valid.
- i_seg_log2, in, 4, segment size = 2^i_seg_log2.
- i_data_flat, in, N_IN*DW, word k at [k*DW +: DW].
- i_byp, in, BYP_W, side-band data carried alongside.
- o_valid, out, 1, output transaction valid.
- o_seg_log2, out, 4, mode travelling with the result.
- o_sum_flat, out, NLANE*DW, lane j at [j*DW +: DW].
- o_lane_vld, out, NLANE, lane j carries a real segment sum.
- o_sat, out, NLANE, lane j result was clamped somewhere in its subtree.
- o_mode_err, out, 1, transaction had an illegal i_seg_log2.
- o_byp, out, BYP_W, i_byp delayed to match.

Behaviour:
- Interface: one clock i_clk; reset i_rst_n is synchronous and active-low.
  - Sampled only at posedge i_clk. Reset takes priority over i_en.
  - Reset clears all pipeline registers; every output reads 0 from the first edge with i_rst_n=0.
- Tree structure:
  - Level 0 = inputs; level l node m = sat_add(level l-1 node 2m, node 2m+1).
  - Each level is one register stage (built-in registered adder, no IP core).
  - Pairing order is fixed adjacent-pair, because saturation makes the result order-dependent.
- Latency: fixed LVL cycles of enabled clocks from i_valid sample to o_valid (6 at defaults).
  - Level l node m (l >= MIN_SEG_LOG2) is delay-matched by LVL-l registers.
  - Every lane and mode therefore appears at the same cycle.
- sat_add:
  - Computes a DW+1-bit exact sum.
  - If the sum exceeds 2^(DW-1)-1, result = 0x7FFF; if below -2^(DW-1), result = 0x8000 (DW=16).
  - Sat flag = own clamp OR either child flag; level 0 flags = 0.
- Lane mapping for mode s:
  - Legal range: MIN_SEG_LOG2 <= s <= LVL.
  - Lane j, for j < N_IN>>s, = level s node j = sum of words j*2^s .. (j+1)*2^s-1.
  - o_lane_vld[j]=1 for those lanes.
  - Remaining lanes: o_sum=0, o_lane_vld=0, o_sat=0.
- Illegal mode (s < MIN_SEG_LOG2 or s > LVL):
  - o_mode_err=1 and all lanes 0, lane_vld 0, sat 0.
  - o_valid still follows i_valid, so downstream can drop the row.
- Mode capture: i_seg_log2, i_valid and i_byp are captured with the data and shifted alongside it.
  - A different mode on consecutive cycles is legal; each result uses its own mode.
- Throughput: one transaction per enabled cycle, no back-pressure; i_en is the only stall.
- i_en=0: all stages hold (including bypass and flags); outputs hold their last values.
  - When i_en returns to 1, results appear after LVL further enabled cycles; nothing is lost or duplicated.
- Qualification of outputs:
  - When o_valid=0, o_sum/o_sat/o_lane_vld hold pipeline contents; data is not forced to zero.
  - Consumers qualify with o_valid.
  - o_mode_err is only meaningful with o_valid=1.
- Reset mid-flight: in-flight transactions are discarded; o_valid=0 until LVL enabled cycles after the first new i_valid.

Test Plan:
1. Defaults, s=6, all 64 words = 0x0010, i_valid pulse at cycle 0 → at cycle 6: o_valid=1, lane0=0x0400, lane_vld=0001, sat=0, lanes1..3=0.
2. s=4, word k = k (0..63) → lanes = 120, 376, 632, 888; lane_vld=1111; o_seg_log2=4; o_byp equals the i_byp sampled 6 cycles earlier.
3. Saturation: s=5, words 0..31 = 0x4000, words 32..63 = 0xC000 → lane0=0x7FFF with sat[0]=1; lane1=0x8000 with sat[1]=1.
   - s=6, words 0,1 = 0x7000, rest 0 → 0x7FFF, sat[0]=1.
4. Back-to-back modes: cycles 0/1/2 carry s=6/5/4 with all words = 1 → cycles 6/7/8 show lane0=64; lanes 0..1 =32; lanes 0..3 =16; lane_vld sequence 0001/0011/1111.
5. Illegal mode: s=3 (and separately s=7) with i_valid=1 → 6 cycles later o_valid=1, o_mode_err=1, all lanes 0, lane_vld=0.
6. Stall and reset:
   - Transaction at cycle 0, i_en=0 for cycles 2..4 → o_valid asserts at cycle 9, data intact.
   - Separately, i_rst_n=0 at cycle 3 → o_valid stays 0 and all outputs read 0 from cycle 4; a new transaction issued after reset appears after exactly 6 cycles.

Source files
------------

// File: rtl/add_tree_seg.sv
`default_nettype none
// ============================================================================
//  Module   : add_tree_seg
//  Purpose  : Pipelined segmented saturating adder tree. Reduces N_IN signed
//             words into per-segment sums at a fixed latency of log2(N_IN).
//  Revision : 1.0
// ============================================================================
module add_tree_seg #(
    parameter int N_IN         = 64,
    parameter int DW           = 16,
    parameter int MIN_SEG_LOG2 = 4,
    parameter int BYP_W        = 1024
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_en,
    input  logic                                i_valid,
    input  logic [3:0]                          i_seg_log2,
    input  logic [N_IN*DW-1:0]                  i_data_flat,
    input  logic [BYP_W-1:0]                    i_byp,
    output logic                                o_valid,
    output logic [3:0]                          o_seg_log2,
    output logic [(N_IN>>MIN_SEG_LOG2)*DW-1:0]  o_sum_flat,
    output logic [(N_IN>>MIN_SEG_LOG2)-1:0]     o_lane_vld,
    output logic [(N_IN>>MIN_SEG_LOG2)-1:0]     o_sat,
    output logic                                o_mode_err,
    output logic [BYP_W-1:0]                    o_byp
);

    localparam int LVL   = $clog2(N_IN);
    localparam int NLANE = N_IN >> MIN_SEG_LOG2;
    localparam int NNODE = N_IN - 2;
    localparam int NPIPE = LVL - 1;

    // Node word: MSB is the sticky saturation flag, low DW bits the sum.
    typedef logic [DW:0] node_t;

    // Levels 1..LVL-1 packed back to back in one array.
    function automatic int node_idx(input int l, input int m);
        return N_IN - (N_IN >> (l - 1)) + m;
    endfunction

    function automatic node_t sat_add(input node_t a, input node_t b);
        logic [DW:0] s;
        logic        ovf;
        node_t       r;
        s     = {a[DW-1], a[DW-1:0]} + {b[DW-1], b[DW-1:0]};
        ovf   = s[DW] ^ s[DW-1];
        r[DW] = a[DW] | b[DW] | ovf;
        if (!ovf)
            r[DW-1:0] = s[DW-1:0];
        else if (s[DW])
            r[DW-1:0] = {1'b1, {(DW-1){1'b0}}};
        else
            r[DW-1:0] = {1'b0, {(DW-1){1'b1}}};
        return r;
    endfunction

    node_t              r_node [NNODE];
    logic [NPIPE-1:0]   r_vld;
    logic [3:0]         r_seg [NPIPE];
    logic [BYP_W-1:0]   r_byp [NPIPE];
    node_t              w_cand [MIN_SEG_LOG2:LVL][NLANE];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int n = 0; n < NNODE; n++)
                r_node[n] <= '0;
        end else if (i_en) begin
            for (int m = 0; m < N_IN / 2; m++)
                r_node[m] <= sat_add({1'b0, i_data_flat[(2*m)*DW +: DW]},
                                     {1'b0, i_data_flat[(2*m+1)*DW +: DW]});
            for (int l = 2; l < LVL; l++)
                for (int m = 0; m < (N_IN >> l); m++)
                    r_node[node_idx(l, m)] <= sat_add(r_node[node_idx(l-1, 2*m)],
                                                      r_node[node_idx(l-1, 2*m+1)]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            for (int p = 0; p < NPIPE; p++) begin
                r_seg[p] <= '0;
                r_byp[p] <= '0;
            end
        end else if (i_en) begin
            r_vld[0] <= i_valid;
            r_seg[0] <= i_seg_log2;
            r_byp[0] <= i_byp;
            for (int p = 1; p < NPIPE; p++) begin
                r_vld[p] <= r_vld[p-1];
                r_seg[p] <= r_seg[p-1];
                r_byp[p] <= r_byp[p-1];
            end
        end
    end

    // Every selectable level is delayed so it lands at stage LVL-1.
    generate
        for (genvar l = MIN_SEG_LOG2; l < LVL; l++) begin : g_lvl
            localparam int NN    = N_IN >> l;
            localparam int DEPTH = LVL - 1 - l;
            if (DEPTH > 0) begin : g_dly
                node_t r_pipe [DEPTH][NN];
                always_ff @(posedge i_clk) begin
                    if (!i_rst_n) begin
                        for (int d = 0; d < DEPTH; d++)
                            for (int m = 0; m < NN; m++)
                                r_pipe[d][m] <= '0;
                    end else if (i_en) begin
                        for (int m = 0; m < NN; m++) begin
                            r_pipe[0][m] <= r_node[node_idx(l, m)];
                            for (int d = 1; d < DEPTH; d++)
                                r_pipe[d][m] <= r_pipe[d-1][m];
                        end
                    end
                end
                for (genvar j = 0; j < NLANE; j++) begin : g_lane
                    if (j < NN) begin : g_on
                        assign w_cand[l][j] = r_pipe[DEPTH-1][j];
                    end else begin : g_off
                        assign w_cand[l][j] = '0;
                    end
                end
            end else begin : g_nodly
                for (genvar j = 0; j < NLANE; j++) begin : g_lane
                    if (j < NN) begin : g_on
                        assign w_cand[l][j] = r_node[node_idx(l, j)];
                    end else begin : g_off
                        assign w_cand[l][j] = '0;
                    end
                end
            end
        end
        for (genvar j = 0; j < NLANE; j++) begin : g_root
            if (j == 0) begin : g_on
                assign w_cand[LVL][j] = sat_add(r_node[node_idx(LVL-1, 0)],
                                                r_node[node_idx(LVL-1, 1)]);
            end else begin : g_off
                assign w_cand[LVL][j] = '0;
            end
        end
    endgenerate

    logic                 w_err;
    logic [NLANE*DW-1:0]  w_sum;
    logic [NLANE-1:0]     w_lvld;
    logic [NLANE-1:0]     w_sat;

    always_comb begin
        w_err  = r_vld[NPIPE-1] &&
                 ((r_seg[NPIPE-1] < 4'(MIN_SEG_LOG2)) || (r_seg[NPIPE-1] > 4'(LVL)));
        w_sum  = '0;
        w_lvld = '0;
        w_sat  = '0;
        for (int l = MIN_SEG_LOG2; l <= LVL; l++) begin
            if (r_seg[NPIPE-1] == 4'(l)) begin
                for (int j = 0; j < (N_IN >> l); j++) begin
                    w_sum[j*DW +: DW] = w_cand[l][j][DW-1:0];
                    w_sat[j]          = w_cand[l][j][DW];
                    w_lvld[j]         = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_valid    <= 1'b0;
            o_seg_log2 <= '0;
            o_sum_flat <= '0;
            o_lane_vld <= '0;
            o_sat      <= '0;
            o_mode_err <= 1'b0;
            o_byp      <= '0;
        end else if (i_en) begin
            o_valid    <= r_vld[NPIPE-1];
            o_seg_log2 <= r_seg[NPIPE-1];
            o_sum_flat <= w_sum;
            o_lane_vld <= w_lvld;
            o_sat      <= w_sat;
            o_mode_err <= w_err;
            o_byp      <= r_byp[NPIPE-1];
        end
    end

endmodule
`default_nettype wire
